// File: rtl/store_checker_pkg.sv
// Shared types for the data-memory store checker.
package store_checker_pkg;

  // Encodings double as the externally visible 2-bit status value.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } status_t;

endpackage

// File: rtl/store_checker_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-low reset.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/store_checker.sv
// Monitors the core's store port against an ordered list of expected
// (address, data) pairs and reports sticky PASS / FAIL / TIMEOUT status.
module store_checker
  import store_checker_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int NUM_CHECKS = 1,
  parameter int TIMEOUT    = 2000,
  parameter int STRICT     = 1,
  parameter int CW         = $clog2(TIMEOUT + 2),
  parameter int IW         = $clog2(NUM_CHECKS + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     mem_write,
  input  logic [AW-1:0]            data_adr,
  input  logic [DW-1:0]            write_data,
  input  logic [NUM_CHECKS*AW-1:0] exp_adr,
  input  logic [NUM_CHECKS*DW-1:0] exp_data,
  input  logic [AW-1:0]            ign_lo,
  input  logic [AW-1:0]            ign_hi,
  output logic                     done,
  output logic                     pass,
  output logic [1:0]               status,
  output logic                     timed_out,
  output logic [IW-1:0]            check_idx,
  output logic [15:0]              store_count,
  output logic [CW-1:0]            cycle_count,
  output logic [AW-1:0]            fail_adr,
  output logic [DW-1:0]            fail_data
);

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CHECKS - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  status_t       state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [AW-1:0] fail_adr_q, fail_adr_d;
  logic [DW-1:0] fail_data_q, fail_data_d;
  logic          timed_out_q, timed_out_d;

  logic [AW-1:0] sel_adr;
  logic [DW-1:0] sel_data;
  logic          in_ign;
  logic          run_active;
  logic          cnt_clr;

  // Expected entry currently awaited.
  always_comb begin
    sel_adr  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      if (idx_q == IW'(i)) begin
        sel_adr  = exp_adr[i*AW +: AW];
        sel_data = exp_data[i*DW +: DW];
      end
    end
  end

  assign in_ign     = (data_adr >= ign_lo) && (data_adr <= ign_hi);
  assign run_active = (state_q == ST_RUN) && enable;
  assign cnt_clr    = (state_q == ST_IDLE) || ((state_q == ST_RUN) && !enable);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    fail_adr_d  = fail_adr_q;
    fail_data_d = fail_data_q;
    timed_out_d = timed_out_q;
    case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        if (enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!enable) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          if (mem_write && !in_ign) begin
            if ((data_adr == sel_adr) && (write_data == sel_data)) begin
              idx_d = idx_q + 1'b1;
              if (idx_q == LAST_IDX) state_d = ST_PASS;
            end else if (STRICT != 0) begin
              state_d     = ST_FAIL;
              fail_adr_d  = data_adr;
              fail_data_d = write_data;
            end
          end
          // A store-driven verdict in the same cycle outranks the timeout.
          if ((TIMEOUT != 0) && (state_d == ST_RUN) && (cycle_count == TO_LAST)) begin
            state_d     = ST_FAIL;
            timed_out_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      fail_adr_q  <= '0;
      fail_data_q <= '0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      fail_adr_q  <= fail_adr_d;
      fail_data_q <= fail_data_d;
      timed_out_q <= timed_out_d;
    end
  end

  sat_counter #(.W(CW)) u_cycles (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (run_active),
    .count (cycle_count)
  );

  sat_counter #(.W(16)) u_stores (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (run_active && mem_write),
    .count (store_count)
  );

  assign status    = state_q;
  assign done      = (state_q == ST_PASS) || (state_q == ST_FAIL);
  assign pass      = (state_q == ST_PASS);
  assign timed_out = timed_out_q;
  assign check_idx = idx_q;
  assign fail_adr  = fail_adr_q;
  assign fail_data = fail_data_q;

endmodule

// File: tb/tb_store_checker.sv
// Scenario and randomized checks for store_checker across three parameter sets.
module tb_store_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] data_adr = '0;
  logic [31:0] write_data = '0;
  logic [31:0] ign_lo = '0;
  logic [31:0] ign_hi = '0;
  logic [31:0] exp_a_adr = '0, exp_a_data = '0;
  logic [95:0] exp_b_adr = '0, exp_b_data = '0;
  logic [31:0] exp_c_adr = '0, exp_c_data = '0;

  logic        done_a, pass_a, to_a, done_b, pass_b, to_b, done_c, pass_c, to_c;
  logic [1:0]  st_a, st_b, st_c;
  logic [0:0]  idx_a, idx_c;
  logic [1:0]  idx_b;
  logic [15:0] sc_a, sc_b, sc_c;
  logic [10:0] cc_a, cc_b;
  logic [3:0]  cc_c;
  logic [31:0] fa_a, fd_a, fa_b, fd_b, fa_c, fd_c;

  int n_chk = 0;
  int n_ok  = 0;

  always #5 clk = ~clk;

  store_checker u_a (
    .clk(clk), .reset(reset), .enable(enable), .mem_write(mem_write),
    .data_adr(data_adr), .write_data(write_data), .exp_adr(exp_a_adr), .exp_data(exp_a_data),
    .ign_lo(ign_lo), .ign_hi(ign_hi), .done(done_a), .pass(pass_a), .status(st_a),
    .timed_out(to_a), .check_idx(idx_a), .store_count(sc_a), .cycle_count(cc_a),
    .fail_adr(fa_a), .fail_data(fd_a)
  );

  store_checker #(.NUM_CHECKS(3), .STRICT(0)) u_b (
    .clk(clk), .reset(reset), .enable(enable), .mem_write(mem_write),
    .data_adr(data_adr), .write_data(write_data), .exp_adr(exp_b_adr), .exp_data(exp_b_data),
    .ign_lo(ign_lo), .ign_hi(ign_hi), .done(done_b), .pass(pass_b), .status(st_b),
    .timed_out(to_b), .check_idx(idx_b), .store_count(sc_b), .cycle_count(cc_b),
    .fail_adr(fa_b), .fail_data(fd_b)
  );

  store_checker #(.TIMEOUT(10)) u_c (
    .clk(clk), .reset(reset), .enable(enable), .mem_write(mem_write),
    .data_adr(data_adr), .write_data(write_data), .exp_adr(exp_c_adr), .exp_data(exp_c_data),
    .ign_lo(ign_lo), .ign_hi(ign_hi), .done(done_c), .pass(pass_c), .status(st_c),
    .timed_out(to_c), .check_idx(idx_c), .store_count(sc_c), .cycle_count(cc_c),
    .fail_adr(fa_c), .fail_data(fd_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    enable    = 1'b0;
    mem_write = 1'b0;
    reset     = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic store(input logic [31:0] adr, input logic [31:0] dat);
    mem_write  = 1'b1;
    data_adr   = adr;
    write_data = dat;
    tick();
    mem_write = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    n_chk++; if (st_a !== 2'd0) $display("FAIL rst_status got %0d want 0", st_a); else n_ok++;
    n_chk++; if ({done_a, pass_a, to_a} !== 3'b000) $display("FAIL rst_flags got %b want 000", {done_a, pass_a, to_a}); else n_ok++;
    n_chk++; if ({sc_a, cc_a, idx_a} !== '0) $display("FAIL rst_counts got %0d/%0d/%0d want 0", sc_a, cc_a, idx_a); else n_ok++;
    n_chk++; if ({fa_a, fd_a} !== '0) $display("FAIL rst_faildata got %h/%h want 0", fa_a, fd_a); else n_ok++;
    reset = 1'b1;
  endtask

  task automatic test_single_pass();
    exp_a_adr = 32'd100; exp_a_data = 32'd25; ign_lo = 32'd96; ign_hi = 32'd96;
    do_reset();
    enable = 1'b1;
    tick();
    store(32'd96, 32'd7);
    store(32'd96, 32'd9);
    store(32'd100, 32'd25);
    n_chk++; if (st_a !== 2'd2) $display("FAIL single_status got %0d want 2", st_a); else n_ok++;
    n_chk++; if ({done_a, pass_a} !== 2'b11) $display("FAIL single_done_pass got %b want 11", {done_a, pass_a}); else n_ok++;
    n_chk++; if (idx_a !== 1'b1) $display("FAIL single_idx got %0d want 1", idx_a); else n_ok++;
    n_chk++; if (sc_a !== 16'd3) $display("FAIL single_stores got %0d want 3", sc_a); else n_ok++;
  endtask

  task automatic test_strict_fail();
    exp_a_adr = 32'd100; exp_a_data = 32'd25; ign_lo = 32'd96; ign_hi = 32'd96;
    do_reset();
    enable = 1'b1;
    tick();
    store(32'd96, 32'd7);
    store(32'd104, 32'd25);
    n_chk++; if (st_a !== 2'd3) $display("FAIL strict_status got %0d want 3", st_a); else n_ok++;
    n_chk++; if (fa_a !== 32'd104 || fd_a !== 32'd25) $display("FAIL strict_faildata got %0d/%0d want 104/25", fa_a, fd_a); else n_ok++;
    n_chk++; if (to_a !== 1'b0) $display("FAIL strict_timedout got %b want 0", to_a); else n_ok++;
    store(32'd100, 32'd25);
    n_chk++; if (st_a !== 2'd3 || pass_a !== 1'b0) $display("FAIL strict_sticky got %0d want 3", st_a); else n_ok++;
    n_chk++; if (sc_a !== 16'd2) $display("FAIL strict_hold_stores got %0d want 2", sc_a); else n_ok++;
  endtask

  task automatic test_subsequence();
    exp_b_adr  = {32'd8, 32'd4, 32'd0};
    exp_b_data = {32'd3, 32'd2, 32'd1};
    ign_lo = 32'd1; ign_hi = 32'd0;
    do_reset();
    enable = 1'b1;
    tick();
    store(32'd0, 32'd1);
    store(32'd20, 32'd5);
    store(32'd4, 32'd2);
    n_chk++; if (st_b !== 2'd1 || idx_b !== 2'd2) $display("FAIL subseq_mid got %0d/%0d want 1/2", st_b, idx_b); else n_ok++;
    store(32'd8, 32'd3);
    n_chk++; if (st_b !== 2'd2 || pass_b !== 1'b1) $display("FAIL subseq_status got %0d want 2", st_b); else n_ok++;
    n_chk++; if (idx_b !== 2'd3 || sc_b !== 16'd4) $display("FAIL subseq_counts got %0d/%0d want 3/4", idx_b, sc_b); else n_ok++;
  endtask

  task automatic test_timeout();
    exp_c_adr = 32'd100; exp_c_data = 32'd25; ign_lo = 32'd1; ign_hi = 32'd0;
    do_reset();
    enable = 1'b1;
    tick();
    repeat (9) tick();
    n_chk++; if (st_c !== 2'd1 || cc_c !== 4'd9) $display("FAIL to_before got %0d/%0d want 1/9", st_c, cc_c); else n_ok++;
    tick();
    n_chk++; if (st_c !== 2'd3 || to_c !== 1'b1) $display("FAIL to_fire got %0d/%b want 3/1", st_c, to_c); else n_ok++;
    n_chk++; if (cc_c !== 4'd10 || done_c !== 1'b1) $display("FAIL to_cycles got %0d want 10", cc_c); else n_ok++;
    n_chk++; if ({fa_c, fd_c} !== '0) $display("FAIL to_faildata got %h/%h want 0", fa_c, fd_c); else n_ok++;
    do_reset();
    enable = 1'b1;
    tick();
    repeat (9) tick();
    store(32'd100, 32'd25);
    n_chk++; if (st_c !== 2'd2 || to_c !== 1'b0) $display("FAIL to_lastpass got %0d/%b want 2/0", st_c, to_c); else n_ok++;
    n_chk++; if (cc_c !== 4'd10) $display("FAIL to_lastpass_cycles got %0d want 10", cc_c); else n_ok++;
  endtask

  task automatic test_enable_and_async_reset();
    exp_a_adr = 32'd100; exp_a_data = 32'd25; ign_lo = 32'd96; ign_hi = 32'd96;
    do_reset();
    enable = 1'b1;
    tick();
    repeat (5) tick();
    n_chk++; if (cc_a !== 11'd5 || st_a !== 2'd1) $display("FAIL en_run got %0d/%0d want 5/1", cc_a, st_a); else n_ok++;
    enable = 1'b0;
    tick();
    n_chk++; if (st_a !== 2'd0 || cc_a !== 11'd0) $display("FAIL en_drop got %0d/%0d want 0/0", st_a, cc_a); else n_ok++;
    // The store offered in the IDLE cycle must not be sampled.
    enable = 1'b1;
    store(32'd100, 32'd25);
    n_chk++; if (st_a !== 2'd1 || sc_a !== 16'd0 || idx_a !== 1'b0) $display("FAIL en_idle_store got %0d/%0d/%0d want 1/0/0", st_a, sc_a, idx_a); else n_ok++;
    store(32'd96, 32'd1);
    n_chk++; if (sc_a !== 16'd1) $display("FAIL en_rerun_stores got %0d want 1", sc_a); else n_ok++;
    reset = 1'b0;
    #2;
    n_chk++; if ({st_a, done_a, pass_a, to_a} !== '0) $display("FAIL async_status got %0d want 0", st_a); else n_ok++;
    n_chk++; if ({sc_a, cc_a, idx_a} !== '0) $display("FAIL async_counts got %0d/%0d want 0/0", sc_a, cc_a); else n_ok++;
    #2;
    reset = 1'b1;
  endtask

  task automatic test_random(input bit use_b, input int iters);
    logic [31:0] pool [5];
    logic [31:0] q_adr [$];
    logic [31:0] q_dat [$];
    logic [31:0] m_fadr, m_fdat;
    int m_status, m_idx, m_st, m_cyc, n_exp, o_status, o_idx, o_st, o_cyc;
    logic [31:0] o_fadr, o_fdat;
    pool = '{32'd0, 32'd4, 32'd8, 32'd96, 32'd100};
    for (int it = 0; it < iters; it++) begin
      n_exp = use_b ? 3 : 1;
      q_adr.delete();
      q_dat.delete();
      for (int k = 0; k < n_exp; k++) begin
        q_adr.push_back(pool[$urandom_range(0, 4)]);
        q_dat.push_back(32'($urandom_range(1, 3)));
      end
      // Entries at the ignore address could never be matched; move them off it.
      for (int k = 0; k < n_exp; k++) if (q_adr[k] == 32'd96) q_adr[k] = 32'd100;
      if (use_b) begin
        exp_b_adr  = {q_adr[2], q_adr[1], q_adr[0]};
        exp_b_data = {q_dat[2], q_dat[1], q_dat[0]};
      end else begin
        exp_a_adr  = q_adr[0];
        exp_a_data = q_dat[0];
      end
      ign_lo = 32'd96; ign_hi = 32'd96;
      do_reset();
      enable = 1'b1;
      tick();
      m_status = 1; m_idx = 0; m_st = 0; m_cyc = 0; m_fadr = '0; m_fdat = '0;
      for (int c = 0; c < 40; c++) begin
        mem_write  = 1'($urandom_range(0, 1));
        data_adr   = pool[$urandom_range(0, 4)];
        write_data = 32'($urandom_range(1, 3));
        if (m_status == 1) begin
          m_cyc++;
          if (mem_write) begin
            m_st++;
            if (!(data_adr >= ign_lo && data_adr <= ign_hi)) begin
              if (data_adr == q_adr[0] && write_data == q_dat[0]) begin
                void'(q_adr.pop_front());
                void'(q_dat.pop_front());
                m_idx++;
                if (q_adr.size() == 0) m_status = 2;
              end else if (!use_b) begin
                m_status = 3; m_fadr = data_adr; m_fdat = write_data;
              end
            end
          end
        end
        tick();
        mem_write = 1'b0;
        o_status = use_b ? int'(st_b) : int'(st_a);
        o_idx    = use_b ? int'(idx_b) : int'(idx_a);
        o_st     = use_b ? int'(sc_b) : int'(sc_a);
        o_cyc    = use_b ? int'(cc_b) : int'(cc_a);
        o_fadr   = use_b ? fa_b : fa_a;
        o_fdat   = use_b ? fd_b : fd_a;
        n_chk++; if (o_status !== m_status) $display("FAIL rnd_status it%0d c%0d got %0d want %0d", it, c, o_status, m_status); else n_ok++;
        n_chk++; if (o_idx !== m_idx || o_st !== m_st) $display("FAIL rnd_counts it%0d c%0d got %0d/%0d want %0d/%0d", it, c, o_idx, o_st, m_idx, m_st); else n_ok++;
        n_chk++; if (o_cyc !== m_cyc) $display("FAIL rnd_cycles it%0d c%0d got %0d want %0d", it, c, o_cyc, m_cyc); else n_ok++;
        n_chk++; if (o_fadr !== m_fadr || o_fdat !== m_fdat) $display("FAIL rnd_faildata it%0d c%0d got %0d/%0d want %0d/%0d", it, c, o_fadr, o_fdat, m_fadr, m_fdat); else n_ok++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_strict_fail();
    test_subsequence();
    test_timeout();
    test_enable_and_async_reset();
    test_random(1'b0, 6);
    test_random(1'b1, 6);
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule

// File: doc/store_checker.md
Name: store_checker

Overview:
- Synthesizable self-check monitor for the single-cycle RISC-V core's data-memory write port.
- Watches mem_write/data_adr/write_data each cycle and compares non-ignored stores against an ordered list of expected (address, data) pairs.
- Reports PASS, FAIL or TIMEOUT as sticky status, so benches and FPGA builds share one checker.
- Generalises the old single-store pass check (address 100 / data 25, address 96 tolerated): parametrised width, store count, timeout, strict/subsequence mode.

Parameters:
- AW, 32, address width
- DW, 32, data width
- NUM_CHECKS, 1, number of expected stores, >=1
- TIMEOUT, 2000, cycles in RUN before TIMEOUT; 0 disables the timeout
- STRICT, 1, 1 = any non-ignored mismatching store fails; 0 = mismatching stores skipped (subsequence match)
- CW, $clog2(TIMEOUT+2), cycle counter width (derived)
- IW, $clog2(NUM_CHECKS+1), index width (derived)

Ports:
- clk  in  1  clock, all logic on posedge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  start/keep checking; 0 holds IDLE
- mem_write  in  1  store strobe from core
- data_adr  in  AW  store address
- write_data  in  DW  store data
- exp_adr  in  NUM_CHECKS*AW  packed expected addresses, entry 0 in LSBs
- exp_data  in  NUM_CHECKS*DW  packed expected data
- ign_lo  in  AW  ignore window low bound, inclusive
- ign_hi  in  AW  ignore window high bound, inclusive; ign_lo>ign_hi = empty window
- done  out  1  terminal state reached
- pass  out  1  status==PASS
- status  out  2  0 IDLE, 1 RUN, 2 PASS, 3 FAIL (TIMEOUT shown as FAIL with timed_out=1)
- timed_out  out  1  failure caused by timeout
- check_idx  out  IW  number of expected stores matched so far
- store_count  out  16  total stores seen in RUN, saturating at 16'hFFFF
- cycle_count  out  CW  cycles spent in RUN, saturating
- fail_adr  out  AW  address of offending store (0 on timeout)
- fail_data  out  DW  data of offending store (0 on timeout)

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0.
- IDLE: counters and index held at 0; enable=1 -> RUN next edge. No stores sampled in the IDLE cycle.
- RUN, each posedge with mem_write=1:
  - store_count++.
  - Address in [ign_lo, ign_hi]: ignored (counted only).
  - Else if (data_adr, write_data) == entry[check_idx]: check_idx++. If check_idx was NUM_CHECKS-1 -> PASS.
  - Else STRICT=1: -> FAIL, latch fail_adr/fail_data.
  - Else STRICT=0: no effect.
- RUN, each cycle: cycle_count++. If TIMEOUT!=0 and cycle_count==TIMEOUT-1 with no terminal transition this cycle -> FAIL, timed_out=1.
- Precedence in one cycle: store-driven PASS/FAIL beats timeout. A matching final store on the timeout cycle gives PASS.
- enable=0 while in RUN: -> IDLE next edge, counters/index cleared.
- PASS/FAIL are sticky: done=1, hold all outputs, ignore enable and stores; only reset exits.
- Latency: status updates on the edge that samples the store; visible one cycle after the store is presented.
- Compares are full-width equality; X on the inputs is not treated specially (the bench drives clean values).
- Asynchronous reset in mid-RUN: immediate return to IDLE, all outputs 0.

Decomposition:
- Package store_checker_pkg: status_t enum (ST_IDLE, ST_RUN, ST_PASS, ST_FAIL) and the 2-bit status encodings.
- Sub-module sat_counter (parametrised width, inc, clr), instantiated for cycle_count and store_count.
- Entry select, compare and FSM live in store_checker.

Test Plan:
- Default params; exp (100,25), ignore 96..96; stores (96,7),(96,9),(100,25) -> PASS, check_idx=1, store_count=3, done=1.
- Same setup; stores (96,7),(104,25) -> FAIL, fail_adr=104, fail_data=25, timed_out=0; later (100,25) keeps FAIL.
- NUM_CHECKS=3, STRICT=0; expected (0,1),(4,2),(8,3); stores (0,1),(20,5),(4,2),(8,3) -> PASS after 4th store, check_idx=3.
- TIMEOUT=10, no stores -> FAIL with timed_out=1, cycle_count=10. Repeat with matching store on cycle 10 -> PASS.
- Drop enable after 5 RUN cycles -> IDLE, cycle_count=0. Re-enable, then assert reset=0 mid-RUN -> all outputs 0 asynchronously, before the next clk edge.
